// File: rtl/isp_stream_pkg.sv
// Shared definitions for the ISP pixel-stream transmit path.
package isp_stream_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned DIM_W_DEF  = 12;
  localparam int unsigned STALL_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK
  } state_e;

endpackage

// File: rtl/isp_raster_counter.sv
// Raster position tracker: hCnt wraps on h_len, vCnt wraps on v_len; flags frame/line edges.
module isp_raster_counter
  import isp_stream_pkg::*;
#(
  parameter int unsigned DIM_W = DIM_W_DEF
) (
  input  logic             isp_clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  input  logic [DIM_W-1:0] h_len,
  input  logic [DIM_W-1:0] v_len,
  output logic             first_pix,
  output logic             last_pix,
  output logic             last_line
);

  logic [DIM_W-1:0] h_cnt_q, h_cnt_d;
  logic [DIM_W-1:0] v_cnt_q, v_cnt_d;

  assign first_pix = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign last_pix  = (h_cnt_q == h_len - DIM_W'(1));
  assign last_line = (v_cnt_q == v_len - DIM_W'(1));

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (clear) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (advance) begin
      if (last_pix) begin
        h_cnt_d = '0;
        v_cnt_d = last_line ? '0 : v_cnt_q + DIM_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge isp_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

endmodule

// File: rtl/isp_frame_streamer.sv
// Pulls pixels from a ready/valid source and emits an h_active x v_active raster
// with programmable line/frame blanking and registered sof/eol/eof markers.
module isp_frame_streamer
  import isp_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DIM_W  = DIM_W_DEF
) (
  input  logic               isp_clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [DIM_W-1:0]   h_active,
  input  logic [DIM_W-1:0]   v_active,
  input  logic [DIM_W-1:0]   h_blank,
  input  logic [DIM_W-1:0]   v_blank,
  input  logic [DATA_W-1:0]  src_data,
  input  logic               src_valid,
  output logic               src_ready,
  output logic [DATA_W-1:0]  dataOut,
  output logic               dataEn,
  output logic               sof,
  output logic               eol,
  output logic               eof,
  output logic               frame_busy,
  output logic               cfg_err,
  output logic [STALL_W-1:0] stall_cnt
);

  state_e state_q, state_d;

  logic [DIM_W-1:0]   h_act_q, h_act_d;
  logic [DIM_W-1:0]   v_act_q, v_act_d;
  logic [DIM_W-1:0]   h_blk_q, h_blk_d;
  logic [DIM_W-1:0]   v_blk_q, v_blk_d;
  logic [DIM_W-1:0]   blank_q, blank_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               en_q, en_d;
  logic               sof_q, sof_d;
  logic               eol_q, eol_d;
  logic               eof_q, eof_d;
  logic               busy_q;
  logic               err_q, err_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic accept;
  logic dims_ok;
  logic boundary;
  logic cnt_adv;
  logic cnt_clr;
  logic first_pix;
  logic last_pix;
  logic last_line;

  assign src_ready = (state_q == ST_ACTIVE);
  assign accept    = src_valid && src_ready;
  assign dims_ok   = (h_active != '0) && (v_active != '0);

  isp_raster_counter #(
    .DIM_W (DIM_W)
  ) u_raster (
    .isp_clk   (isp_clk),
    .rst_n     (rst_n),
    .clear     (cnt_clr),
    .advance   (cnt_adv),
    .h_len     (h_act_q),
    .v_len     (v_act_q),
    .first_pix (first_pix),
    .last_pix  (last_pix),
    .last_line (last_line)
  );

  always_comb begin
    state_d  = state_q;
    h_act_d  = h_act_q;
    v_act_d  = v_act_q;
    h_blk_d  = h_blk_q;
    v_blk_d  = v_blk_q;
    blank_d  = blank_q;
    data_d   = data_q;
    en_d     = 1'b0;
    sof_d    = 1'b0;
    eol_d    = 1'b0;
    eof_d    = 1'b0;
    err_d    = 1'b0;
    stall_d  = stall_q;
    cnt_adv  = 1'b0;
    cnt_clr  = 1'b0;
    boundary = 1'b0;

    unique case (state_q)
      ST_IDLE: boundary = 1'b1;

      ST_ACTIVE: begin
        if (accept) begin
          data_d  = src_data;
          en_d    = 1'b1;
          sof_d   = first_pix;
          eol_d   = last_pix;
          eof_d   = last_pix && last_line;
          cnt_adv = 1'b1;
          if (last_pix) begin
            if (last_line) begin
              if (v_blk_q == '0) begin
                boundary = 1'b1;
              end else begin
                state_d = ST_VBLANK;
                blank_d = '0;
              end
            end else if (h_blk_q != '0) begin
              state_d = ST_HBLANK;
              blank_d = '0;
            end
          end
        end else if (stall_q != '1) begin
          stall_d = stall_q + STALL_W'(1);
        end
      end

      ST_HBLANK: begin
        if (blank_q == h_blk_q - DIM_W'(1)) begin
          state_d = ST_ACTIVE;
          blank_d = '0;
        end else begin
          blank_d = blank_q + DIM_W'(1);
        end
      end

      ST_VBLANK: begin
        if (blank_q == v_blk_q - DIM_W'(1)) begin
          boundary = 1'b1;
          blank_d  = '0;
        end else begin
          blank_d = blank_q + DIM_W'(1);
        end
      end
    endcase

    // Frame boundary shared by IDLE, VBLANK exit and zero-v_blank frame end.
    // A rejected start pulses cfg_err at most every other cycle.
    if (boundary) begin
      if (enable && dims_ok) begin
        state_d = ST_ACTIVE;
        h_act_d = h_active;
        v_act_d = v_active;
        h_blk_d = h_blank;
        v_blk_d = v_blank;
        stall_d = '0;
        cnt_clr = 1'b1;
      end else begin
        state_d = ST_IDLE;
        err_d   = enable && !err_q;
      end
    end
  end

  always_ff @(posedge isp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_act_q <= '0;
      v_act_q <= '0;
      h_blk_q <= '0;
      v_blk_q <= '0;
      blank_q <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      h_act_q <= h_act_d;
      v_act_q <= v_act_d;
      h_blk_q <= h_blk_d;
      v_blk_q <= v_blk_d;
      blank_q <= blank_d;
      data_q  <= data_d;
      en_q    <= en_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      busy_q  <= (state_d != ST_IDLE);
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign dataOut    = data_q;
  assign dataEn     = en_q;
  assign sof        = sof_q;
  assign eol        = eol_q;
  assign eof        = eof_q;
  assign frame_busy = busy_q;
  assign cfg_err    = err_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_isp_frame_streamer.sv
// Scoreboard bench for isp_frame_streamer: frame model fills a queue, a monitor pops on dataEn.
module tb_isp_frame_streamer;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          isp_clk   = 1'b0;
  logic          rst_n     = 1'b0;
  logic          enable    = 1'b0;
  logic [AW-1:0] h_active  = 12'd4;
  logic [AW-1:0] v_active  = 12'd3;
  logic [AW-1:0] h_blank   = 12'd2;
  logic [AW-1:0] v_blank   = 12'd3;
  logic [DW-1:0] src_data  = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [DW-1:0] dataOut;
  logic          dataEn, sof, eol, eof, frame_busy, cfg_err;
  logic [15:0]   stall_cnt;

  isp_frame_streamer #(
    .DATA_W (DW),
    .DIM_W  (AW)
  ) dut (
    .isp_clk    (isp_clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .h_active   (h_active),
    .v_active   (v_active),
    .h_blank    (h_blank),
    .v_blank    (v_blank),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .dataOut    (dataOut),
    .dataEn     (dataEn),
    .sof        (sof),
    .eol        (eol),
    .eof        (eof),
    .frame_busy (frame_busy),
    .cfg_err    (cfg_err),
    .stall_cnt  (stall_cnt)
  );

  always #5 isp_clk = ~isp_clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
    logic          l;
    logic          e;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] stream_q[$];
  int            stamp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;

  always @(posedge isp_clk) cyc <= cyc + 1;

  // Monitor: every presented pixel must match the head of the expected queue.
  always @(negedge isp_clk) begin
    exp_t e;
    if (rst_n) begin
      checks++;
      if (dataEn) begin
        stamp_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got data %0h with dataEn, expected no pixel", dataOut);
        end else begin
          e = exp_q.pop_front();
          if ({dataOut, sof, eol, eof} !== {e.d, e.s, e.l, e.e}) begin
            errors++;
            $display("FAIL pixel: got data %0h sof/eol/eof %b%b%b, expected data %0h sof/eol/eof %b%b%b",
                     dataOut, sof, eol, eof, e.d, e.s, e.l, e.e);
          end
        end
      end else if (sof || eol || eof) begin
        errors++;
        $display("FAIL marker_without_dataEn: got sof/eol/eof %b%b%b, expected 000", sof, eol, eof);
      end
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model of one frame: raster order, markers derived from pixel index.
  task automatic push_frame(input int h, input int v, input bit rnd);
    exp_t          e;
    logic [DW-1:0] d;
    for (int i = 0; i < h * v; i++) begin
      d   = rnd ? DW'($urandom) : DW'(stream_q.size());
      e.d = d;
      e.s = (i == 0);
      e.l = ((i % h) == h - 1);
      e.e = (i == h * v - 1);
      exp_q.push_back(e);
      stream_q.push_back(d);
    end
  endtask

  task automatic new_test();
    stream_q.delete();
    stamp_q.delete();
  endtask

  // Ready/valid source offering stream_q in order; hooks keyed on pixels already transferred.
  task automatic run_source(input int prob, input bit pulse, input int stall_at, input int stall_len,
                            input int chg_at, input int new_h, input int rst_at);
    int k, iter, stall_left;
    bit stall_done;
    k = 0; iter = 0; stall_left = 0; stall_done = 1'b0;
    while (k < stream_q.size()) begin
      @(negedge isp_clk);
      iter++;
      if (iter > 3000) begin
        checks++;
        errors++;
        $display("FAIL source_timeout: got %0d pixels accepted, expected %0d", k, stream_q.size());
        break;
      end
      if (pulse && iter == 1) enable = 1'b0;
      if (k == chg_at) begin
        enable   = 1'b0;
        h_active = AW'(new_h);
        chg_at   = -1;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("reset_outputs_cleared",
              {dataOut, dataEn, sof, eol, eof, frame_busy, cfg_err, stall_cnt, src_ready}, 0);
        src_valid = 1'b0;
        return;
      end
      if (k == stall_at && !stall_done) begin
        stall_left = stall_len;
        stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        src_valid = 1'b0;
        stall_left--;
      end else begin
        src_valid = (int'($urandom_range(99)) < prob);
        src_data  = stream_q[k];
      end
      if (src_valid && src_ready) k++;
    end
    @(negedge isp_clk);
    src_valid = 1'b0;
  endtask

  task automatic wait_idle(output int fall);
    fall = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge isp_clk);
      if (!frame_busy) begin
        fall = cyc;
        break;
      end
    end
    check("frame_busy_falls", (fall >= 0), 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic set_geom(input int h, input int v, input int hb, input int vb);
    h_active = AW'(h);
    v_active = AW'(v);
    h_blank  = AW'(hb);
    v_blank  = AW'(vb);
  endtask

  initial begin
    int fall, cnt, consec;
    bit prev;
    int h, v;

    repeat (3) @(negedge isp_clk);
    check("reset_state",
          {dataOut, dataEn, sof, eol, eof, frame_busy, cfg_err, stall_cnt, src_ready}, 0);
    rst_n = 1'b1;
    @(negedge isp_clk);

    // 4x3, blanks 2/3, source always valid, single-cycle enable
    new_test();
    set_geom(4, 3, 2, 3);
    push_frame(4, 3, 1'b0);
    enable = 1'b1;
    run_source(100, 1'b1, -1, 0, -1, 0, -1);
    wait_idle(fall);
    check("t1_pixel_count", stamp_q.size(), 12);
    if (stamp_q.size() == 12) begin
      for (int i = 1; i < 12; i++)
        check($sformatf("t1_gap_%0d", i), stamp_q[i] - stamp_q[i-1], (i % 4 == 0) ? 3 : 1);
      check("t1_vblank_len", fall - stamp_q[11], 3);
    end
    check("t1_stall_cnt", stall_cnt, 0);

    // Same geometry, 5-cycle source stall in the middle of line 2
    new_test();
    push_frame(4, 3, 1'b0);
    enable = 1'b1;
    run_source(100, 1'b1, 6, 5, -1, 0, -1);
    wait_idle(fall);
    check("t2_pixel_count", stamp_q.size(), 12);
    if (stamp_q.size() == 12) check("t2_stall_gap", stamp_q[6] - stamp_q[5], 6);
    check("t2_stall_cnt", stall_cnt, 5);

    // No blanking, enable held: two frames back to back
    new_test();
    set_geom(4, 3, 0, 0);
    push_frame(4, 3, 1'b0);
    push_frame(4, 3, 1'b0);
    enable = 1'b1;
    run_source(100, 1'b0, -1, 0, 13, 4, -1);
    wait_idle(fall);
    check("t3_pixel_count", stamp_q.size(), 24);
    if (stamp_q.size() == 24) check("t3_contiguous", stamp_q[23] - stamp_q[0], 23);

    // Enable dropped and width changed mid-frame: frame completes at the old width
    new_test();
    set_geom(4, 3, 2, 3);
    push_frame(4, 3, 1'b1);
    enable = 1'b1;
    run_source(80, 1'b0, -1, 0, 6, 8, -1);
    wait_idle(fall);
    check("t4_pixel_count", stamp_q.size(), 12);
    check("t4_busy_after", frame_busy, 0);
    h_active = 12'd4;

    // Zero width: rejected start
    new_test();
    h_active = 12'd0;
    enable   = 1'b1;
    cnt = 0; consec = 0; prev = 1'b0;
    repeat (6) begin
      @(negedge isp_clk);
      check("cfg_src_ready", src_ready, 0);
      check("cfg_frame_busy", frame_busy, 0);
      if (cfg_err) cnt++;
      if (cfg_err && prev) consec++;
      prev = cfg_err;
    end
    enable = 1'b0;
    repeat (2) @(negedge isp_clk);
    check("cfg_err_pulsed", (cnt > 0), 1);
    check("cfg_err_single_cycle", consec, 0);
    check("cfg_err_clears", cfg_err, 0);
    h_active = 12'd4;

    // Reset at pixel 7, then a fresh frame starts cleanly
    new_test();
    set_geom(4, 3, 2, 3);
    push_frame(4, 3, 1'b1);
    enable = 1'b1;
    run_source(100, 1'b0, -1, 0, -1, 0, 7);
    @(negedge isp_clk);
    exp_q.delete();
    new_test();
    push_frame(4, 3, 1'b1);
    @(negedge isp_clk);
    rst_n = 1'b1;
    run_source(100, 1'b0, -1, 0, 2, 4, -1);
    wait_idle(fall);
    check("t6_pixel_count", stamp_q.size(), 12);

    // Randomised geometries, first one 1x1
    for (int it = 0; it < 8; it++) begin
      new_test();
      h = (it == 0) ? 1 : int'($urandom_range(5, 1));
      v = (it == 0) ? 1 : int'($urandom_range(4, 1));
      set_geom(h, v, int'($urandom_range(3)), int'($urandom_range(3)));
      push_frame(h, v, 1'b1);
      enable = 1'b1;
      run_source(int'($urandom_range(100, 50)), 1'b1, -1, 0, -1, 0, -1);
      wait_idle(fall);
      check($sformatf("rand%0d_pixel_count", it), stamp_q.size(), h * v);
    end

    repeat (3) @(negedge isp_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/isp_frame_streamer.md
Name: isp_frame_streamer

Overview:
Transmit side of the ISP pixel-stream interface consumed by the 5x5 window generator. Pulls pixels from an upstream ready/valid source and emits a raster of h_active x v_active pixels on dataOut/dataEn. Blanking gaps between lines and frames are programmable. Emits sof/eol/eof markers aligned with the consumer's counters. Sits between the sensor/DDR read path and the window/filter chain.

Parameters:
DATA_W, 16, pixel width
DIM_W, 12, width of all dimension/counter fields

Ports:
isp_clk  input  1  pixel clock
rst_n  input  1  reset, asynchronous, active-low
enable  input  1  level; while high, frames are streamed back-to-back
h_active  input  DIM_W  pixels per line
v_active  input  DIM_W  lines per frame
h_blank  input  DIM_W  idle cycles after each non-final line
v_blank  input  DIM_W  idle cycles after final line
src_data  input  DATA_W  upstream pixel
src_valid  input  1  upstream pixel valid
src_ready  output  1  streamer accepts src_data this cycle
dataOut  output  DATA_W  pixel to consumer
dataEn  output  1  dataOut valid
sof  output  1  with first pixel of frame
eol  output  1  with last pixel of each line
eof  output  1  with last pixel of frame
frame_busy  output  1  state != IDLE
cfg_err  output  1  one-cycle pulse on rejected start
stall_cnt  output  16  cycles in ACTIVE with src_valid low this frame, saturating

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Config sampling: h_active, v_active, h_blank and v_blank are latched at frame start (IDLE->ACTIVE or VBLANK->ACTIVE). Changes mid-frame have no effect.
- FSM states:
  - IDLE
    - enable=1 with h_active!=0 and v_active!=0 -> latch config, clear stall_cnt, go to ACTIVE.
    - enable=1 with either dimension 0 -> pulse cfg_err, stay IDLE. Re-pulses every 1st cycle of each attempt; attempts are spaced one cycle apart.
  - ACTIVE
    - src_ready = 1, combinational from state (no dependence on src_valid).
    - Accept = src_valid & src_ready.
    - On accept: next cycle dataOut=src_data and dataEn=1. Latency is exactly 1 cycle. hCnt increments.
    - No accept: next cycle dataEn=0, dataOut holds its last value, stall_cnt++ (saturates at 16'hFFFF).
    - Accept of pixel hCnt==h_active-1:
      - eol=1 with that pixel; hCnt->0.
      - If vCnt==v_active-1: eof=1, vCnt->0, go to VBLANK (or apply the VBLANK exit rule directly if v_blank==0).
      - Otherwise: vCnt++ and go to HBLANK, or stay ACTIVE if h_blank==0.
    - sof=1 with the pixel accepted at hCnt==0, vCnt==0.
  - HBLANK
    - src_ready=0. Counts h_blank cycles (blank counter b from 0 to h_blank-1), then returns to ACTIVE.
  - VBLANK
    - src_ready=0. Counts v_blank cycles.
    - Exit: enable=1 -> re-latch config and start the next frame in ACTIVE (zero-dimension check applies, failing -> cfg_err, IDLE). enable=0 -> IDLE.
- Deasserting enable mid-frame never truncates a frame; the current frame always completes.
- sof/eol/eof/dataEn are registered together and are single-cycle. For a 1x1 frame, sof, eol and eof all assert on the same pixel.
- Pixel count per frame is exactly h_active*v_active dataEn pulses. eof coincides with the cycle where a consumer sees hCnt==h_active-1 and vCnt==v_active-1 with dataEn.
- Async reset mid-frame: immediate return to IDLE with all outputs cleared; no partial-frame recovery.
- frame_busy is registered state!=IDLE.

Decomposition:
- Shared package isp_stream_pkg: DATA_W and DIM_W defaults, FSM state enum (IDLE, ACTIVE, HBLANK, VBLANK), constant STALL_W=16.
- One sub-module, isp_raster_counter: hCnt/vCnt with wrap on the latched h_active/v_active. Inputs: advance, clear. Outputs: last_pix, last_line, first_pix. The window generator may reuse it.

Test Plan:
- Geometry h_active=4, v_active=3, h_blank=2, v_blank=3; src_valid always 1; enable pulsed 1 cycle -> exactly 12 dataEn pulses, pattern 4 on / 2 off / 4 on / 2 off / 4 on. sof on pixel 1, eol on pixels 4/8/12, eof on pixel 12. Then 3 blank cycles, then IDLE, stall_cnt=0.
- Same geometry with src_valid low for 5 cycles mid-line 2 -> dataEn gap of 5, pixel order preserved (data=index 0..11), stall_cnt=5, eof still on 12th pixel.
- h_blank=0, v_blank=0, enable held high, 2 frames of 4x3 -> 24 contiguous dataEn pulses, sof on pixels 1 and 13, eof on pixels 12 and 24.
- Frame 1 running, enable dropped at pixel 6 and h_active changed to 8 -> frame finishes with 12 pixels at the old width, then IDLE, frame_busy falls after VBLANK.
- h_active=0 with enable=1 -> cfg_err pulses, src_ready stays 0, no dataEn.
- rst_n asserted at pixel 7 -> all outputs 0 the same cycle. After release with enable=1, a new frame starts with sof on the first pixel.
